muldiv_ctrl: RTL

EX-stage controller for the HI/LO datapath of the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and computes multiply results in one cycle. It sequences a 32-iteration radix-2 divider, stalling EX while the divider runs. It issues exactly one registered write strobe set per retired instruction to the HI/LO register.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/div_radix2_iter.sv | 47 ++++
 rtl/muldiv_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// The MULDIV_DIV0_FAST_EN build option is consumed by muldiv_ctrl.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned DIV_CNT_W = 5;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] x);
        return neg ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> HI/LO controller bundle: instruction side in, stall and HI/LO write port out.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            valid_e;
    logic [2:0]      op_e;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush_e;
    logic            stall_e;
    logic            busy;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] hi_wdata;
    logic [XLEN-1:0] lo_wdata;
    logic            div_zero;

    modport master (
        output valid_e, op_e, src_a, src_b, flush_e,
        input  stall_e, busy, hi_we, lo_we, hi_wdata, lo_wdata, div_zero
    );

    modport slave (
        input  valid_e, op_e, src_a, src_b, flush_e,
        output stall_e, busy, hi_we, lo_we, hi_wdata, lo_wdata, div_zero
    );

endinterface

// File: rtl/div_radix2_iter.sv
// One restoring radix-2 division step with its partial-remainder, quotient and divisor registers.
module div_radix2_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            clear,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt_c,
    output logic [XLEN-1:0] quo_nxt_c
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    // quo_q doubles as the dividend shift register; quotient bits enter from the right
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        ge        = shifted >= {1'b0, dvs_q};
        diff      = shifted[XLEN-1:0] - dvs_q;
        rem_nxt_c = ge ? diff : shifted[XLEN-1:0];
        quo_nxt_c = {quo_q[XLEN-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_nxt_c;
            quo_q <= quo_nxt_c;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO controller: single-cycle multiply, MTHI/MTLO, 32-step sequenced divide.
// Build option MULDIV_DIV0_FAST_EN: zero divisor skips the iterations and drives div_zero.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    state_t                state_q, state_d;
    logic [DIV_CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]       a_q, b_q;
    logic                  signed_q, sign_a_q, sign_b_q;
    logic                  hi_we_q, lo_we_q;
    hilo_t                 wdata_q, div_res, mul_res;
    logic [2*XLEN-1:0]     mul_a, mul_b;
    logic [XLEN-1:0]       rem_c, quo_c;
    logic                  accept, is_div_op, last_iter, b_zero, sign_a_c, sign_b_c;
    logic                  div_load, div_step, div_clear, to_done, kill;

    assign accept    = (state_q == ST_IDLE) && bus.valid_e && !bus.flush_e && !rst;
    assign is_div_op = (bus.op_e == OP_DIV) || (bus.op_e == OP_DIVU);
    assign last_iter = (cnt_q == DIV_CNT_W'(DIV_ITERS - 1));
    assign b_zero    = (b_q == '0);
    assign sign_a_c  = signed_q & a_q[XLEN-1];
    assign sign_b_c  = signed_q & b_q[XLEN-1];
    assign kill      = (state_q == ST_DONE) && bus.flush_e;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_div_op) state_d = ST_PREP;
            ST_PREP: begin
                if (bus.flush_e) state_d = ST_IDLE;
`ifdef MULDIV_DIV0_FAST_EN
                else if (b_zero) state_d = ST_DONE;
`endif
                else             state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.flush_e)    state_d = ST_IDLE;
                else if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // stall is combinational so EX holds in the very cycle a divide is accepted
    always_comb begin
        bus.stall_e = 1'b0;
        bus.busy    = (state_q != ST_IDLE);
        div_load    = 1'b0;
        div_step    = 1'b0;
        div_clear   = 1'b0;
        to_done     = 1'b0;
        case (state_q)
            ST_IDLE: bus.stall_e = accept && is_div_op;
            ST_PREP: begin
                bus.stall_e = !bus.flush_e;
                div_load    = !bus.flush_e;
                div_clear   = bus.flush_e;
                to_done     = (state_d == ST_DONE);
            end
            ST_RUN: begin
                bus.stall_e = !bus.flush_e;
                div_step    = !bus.flush_e;
                div_clear   = bus.flush_e;
                to_done     = (state_d == ST_DONE);
            end
            default: ;
        endcase
    end

    div_radix2_iter u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .clear     (div_clear),
        .dividend  (neg_if(sign_a_c, a_q)),
        .divisor   (neg_if(sign_b_c, b_q)),
        .rem_nxt_c (rem_c),
        .quo_nxt_c (quo_c)
    );

    // Operands are captured at accept; signs are fixed in PREP
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (accept && is_div_op) begin
                a_q      <= bus.src_a;
                b_q      <= bus.src_b;
                signed_q <= (bus.op_e == OP_DIV);
            end
            if (div_load) begin
                sign_a_q <= sign_a_c;
                sign_b_q <= sign_b_c;
            end
            cnt_q <= div_step ? cnt_q + DIV_CNT_W'(1) : '0;
        end
    end

    // Sign-extended 64-bit product; the low 64 bits are correct for both signednesses
    always_comb begin
        mul_a   = {{XLEN{(bus.op_e == OP_MULT) & bus.src_a[XLEN-1]}}, bus.src_a};
        mul_b   = {{XLEN{(bus.op_e == OP_MULT) & bus.src_b[XLEN-1]}}, bus.src_b};
        mul_res = mul_a * mul_b;
    end

    always_comb begin
        if (b_zero) begin
            div_res.hi = a_q;
            div_res.lo = '1;
        end else begin
            div_res.hi = neg_if(sign_a_q, rem_c);
            div_res.lo = neg_if(sign_a_q ^ sign_b_q, quo_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            if (accept) begin
                case (bus.op_e)
                    OP_MULT, OP_MULTU: begin
                        hi_we_q <= 1'b1;
                        lo_we_q <= 1'b1;
                        wdata_q <= mul_res;
                    end
                    OP_MTHI: begin
                        hi_we_q    <= 1'b1;
                        wdata_q.hi <= bus.src_a;
                    end
                    OP_MTLO: begin
                        lo_we_q    <= 1'b1;
                        wdata_q.lo <= bus.src_a;
                    end
                    default: ;
                endcase
            end else if (to_done) begin
                hi_we_q <= 1'b1;
                lo_we_q <= 1'b1;
                wdata_q <= div_res;
            end
        end
    end

    // A flush in DONE drops the divide result; earlier MULT/MT* pulses are never in DONE
    assign bus.hi_we    = hi_we_q & ~kill;
    assign bus.lo_we    = lo_we_q & ~kill;
    assign bus.hi_wdata = wdata_q.hi;
    assign bus.lo_wdata = wdata_q.lo;

`ifdef MULDIV_DIV0_FAST_EN
    logic div_zero_q;

    always_ff @(posedge clk) begin
        if (rst) div_zero_q <= 1'b0;
        else     div_zero_q <= to_done && b_zero;
    end

    assign bus.div_zero = div_zero_q & ~kill;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule
